sdr_cmd_decoder: RTL

//  UART command decoder placed between uart_rx and the NCO/CIC control inputs.

---
 rtl/sdr_cmd_decoder.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/sdr_cmd_decoder.sv
// UART command decoder: maps received bytes onto the NCO phase increment and CIC gain.
// Latency: a byte strobed in cycle N updates outputs and pulses in cycle N+1.
// Backpressure: none; every strobed byte is consumed, and hex frames abort on a bad byte or a timeout.
module sdr_cmd_decoder #(
   parameter int                 PHASE_WIDTH    = 64,
   parameter int                 GAIN_WIDTH     = 8,
   parameter logic [63:0]        DEFAULT_PHASE  = 64'h04CF41F212D77318,
   parameter logic [63:0]        STEP_9K        = 64'h00071B375868D170,
   parameter logic [63:0]        STEP_1K        = 64'h0000CA22980BA57E,
   parameter logic [63:0]        STEP_100       = 64'h00001436A8CDF6F3,
   parameter int                 TIMEOUT_CYCLES = 8_000_000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rx_data_valid,
   input  logic [7:0]             rx_byte,
   output logic [PHASE_WIDTH-1:0] phase_inc,
   output logic [GAIN_WIDTH-1:0]  cic_gain,
   output logic                   cmd_update,
   output logic                   cmd_error
);

   localparam int PW = PHASE_WIDTH;
   localparam int GW = GAIN_WIDTH;
   localparam int DW = $clog2(PW / 4 + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [PW-1:0] NYQ       = {1'b0, {(PW-1){1'b1}}};
   localparam logic [PW-1:0] DEF_PH    = PW'(DEFAULT_PHASE);
   localparam logic [PW-1:0] S9K       = PW'(STEP_9K);
   localparam logic [PW-1:0] S1K       = PW'(STEP_1K);
   localparam logic [PW-1:0] S100      = PW'(STEP_100);
   localparam logic [DW-1:0] LAST_PH   = DW'(PW / 4 - 1);
   localparam logic [DW-1:0] LAST_GN   = DW'(GW / 4 - 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, HEX_PHASE, HEX_GAIN} state_t;

   state_t          state, state_nxt;
   logic [PW-1:0]   phase_nxt, shadow, shadow_nxt, shifted;
   logic [GW-1:0]   gain_nxt;
   logic            upd_nxt, err_nxt;
   logic [DW-1:0]   dcnt, dcnt_nxt, last_digit;
   logic [TW-1:0]   tmo, tmo_nxt;

   function automatic logic is_hex(input logic [7:0] b);
      return (b >= "0" && b <= "9") || (b >= "A" && b <= "F") || (b >= "a" && b <= "f");
   endfunction

   // Letters share the low nibble pattern in both cases: 'A'/'a' end in 1, so add 9.
   function automatic logic [3:0] hex_val(input logic [7:0] b);
      return (b <= "9") ? b[3:0] : b[3:0] + 4'd9;
   endfunction

   // Increments saturate at the Nyquist limit instead of wrapping into negative frequencies.
   function automatic logic [PW-1:0] sat_add(input logic [PW-1:0] a, input logic [PW-1:0] b);
      logic [PW:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s > {1'b0, NYQ}) ? NYQ : s[PW-1:0];
   endfunction

   function automatic logic [PW-1:0] sat_sub(input logic [PW-1:0] a, input logic [PW-1:0] b);
      return (a < b) ? '0 : a - b;
   endfunction

   assign shifted    = {shadow[PW-5:0], hex_val(rx_byte)};
   assign last_digit = (state == HEX_PHASE) ? LAST_PH : LAST_GN;

   // Next-state and next-output decode for both single-byte commands and hex frames.
   always_comb begin
      state_nxt  = state;
      phase_nxt  = phase_inc;
      gain_nxt   = cic_gain;
      upd_nxt    = 1'b0;
      err_nxt    = 1'b0;
      dcnt_nxt   = dcnt;
      shadow_nxt = shadow;
      tmo_nxt    = tmo;
      case (state)
         IDLE: begin
            dcnt_nxt   = '0;
            shadow_nxt = '0;
            tmo_nxt    = '0;
            if (rx_data_valid) begin
               upd_nxt = 1'b1;
               case (rx_byte)
                  "0", "1", "2", "3": gain_nxt = GW'(rx_byte[1:0]);
                  "a": phase_nxt = DEF_PH;
                  "b": phase_nxt = PW'(64'h01AA60F8B8911654);
                  "f": phase_nxt = PW'(64'h1DC38C076704516D);
                  "g": phase_nxt = PW'(64'h1D60D923295482C6);
                  "n": phase_nxt = sat_sub(phase_inc, S9K);
                  "m": phase_nxt = sat_add(phase_inc, S9K);
                  "q": phase_nxt = sat_sub(phase_inc, S1K);
                  "r": phase_nxt = sat_add(phase_inc, S1K);
                  "o": phase_nxt = sat_sub(phase_inc, S100);
                  "p": phase_nxt = sat_add(phase_inc, S100);
                  "F": begin state_nxt = HEX_PHASE; upd_nxt = 1'b0; end
                  "G": begin state_nxt = HEX_GAIN;  upd_nxt = 1'b0; end
                  8'h0D, 8'h0A: upd_nxt = 1'b0;
                  default: begin upd_nxt = 1'b0; err_nxt = 1'b1; end
               endcase
            end
         end
         HEX_PHASE, HEX_GAIN: begin
            if (rx_data_valid) begin
               if (is_hex(rx_byte)) begin
                  shadow_nxt = shifted;
                  tmo_nxt    = '0;
                  dcnt_nxt   = dcnt + 1'b1;
                  if (dcnt == last_digit) begin
                     upd_nxt   = 1'b1;
                     state_nxt = IDLE;
                     if (state == HEX_PHASE) phase_nxt = (shifted > NYQ) ? NYQ : shifted;
                     else                    gain_nxt  = shifted[GW-1:0];
                  end
               end else begin
                  err_nxt   = 1'b1;
                  state_nxt = IDLE;
               end
            end else if (tmo == TMO_LAST) begin
               err_nxt   = 1'b1;
               state_nxt = IDLE;
            end else begin
               tmo_nxt = tmo + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, outputs and frame bookkeeping registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         phase_inc  <= DEF_PH;
         cic_gain   <= '0;
         cmd_update <= 1'b0;
         cmd_error  <= 1'b0;
         dcnt       <= '0;
         shadow     <= '0;
         tmo        <= '0;
      end else begin
         state      <= state_nxt;
         phase_inc  <= phase_nxt;
         cic_gain   <= gain_nxt;
         cmd_update <= upd_nxt;
         cmd_error  <= err_nxt;
         dcnt       <= dcnt_nxt;
         shadow     <= shadow_nxt;
         tmo        <= tmo_nxt;
      end
   end

endmodule
